// File: rtl/pck_isa_zicsr.sv
`default_nettype none
// ============================================================================
// Package     : pck_isa_zicsr
// Description : Zicsr funct3 encodings, CSR address map, bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package pck_isa_zicsr;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_TEST      = 12'hBEB;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MEIE_BIT     = 11;
    localparam int MEIP_BIT         = 11;

    // Address bits [11:10] == 2'b11 mark the read-only CSR space.
    function automatic logic csr_is_readonly(input logic [11:0] addr);
        return (addr & 12'hC00) == 12'hC00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zicsr_counter64.sv
`default_nettype none
// ============================================================================
// Module      : zicsr_counter64
// Description : 64-bit wrapping counter with independent 32-bit half writes.
// Revision    : 1.0 - initial release
// ============================================================================
module zicsr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // A write to either half suppresses the increment (and its carry) for the cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i;
            if (wr_hi_i) cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/zicsr_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : zicsr_csr_file
// Description : Machine-mode Zicsr register file with counters and trap state.
// Revision    : 1.0 - initial release
// ============================================================================
module zicsr_csr_file
    import pck_isa_zicsr::*;
#(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MVENDOR_ID = 32'd0,
    parameter logic [31:0] MARCH_ID   = 32'd0,
    parameter logic [31:0] MIMP_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
    input  logic        p_clk_i,
    input  logic        p_reset_i,
    input  logic        csr_valid_i,
    input  logic [2:0]  csr_funct3_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_rs1_data_i,
    input  logic [4:0]  csr_rs1_idx_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_rvalid_o,
    output logic        csr_illegal_o,
    input  logic        instret_i,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    output logic [31:0] mepc_o,
    output logic        mstatus_mie_o,
    input  logic        irq_ext_i
);

    logic        rvalid_q, illegal_q;
    logic [31:0] rdata_q, test_q, mepc_q, mcause_q, mtval_q;
    logic        mie_q, mpie_q, meie_q, meip_q;
    logic [63:0] w_mcycle, w_minstret;

    logic [31:0] w_src, w_old, w_new;
    logic        w_known, w_bad_op, w_wr_req, w_illegal, w_wr_en;

    always_comb begin
        w_src    = csr_funct3_i[2] ? {27'd0, csr_rs1_idx_i} : csr_rs1_data_i;
        w_new    = w_src;
        w_bad_op = 1'b0;
        w_wr_req = (csr_rs1_idx_i != 5'd0);
        unique case (csr_funct3_i)
            F3_CSRRW, F3_CSRRWI: begin
                w_new    = w_src;
                w_wr_req = 1'b1;
            end
            F3_CSRRS, F3_CSRRSI: w_new = w_old | w_src;
            F3_CSRRC, F3_CSRRCI: w_new = w_old & ~w_src;
            default:             w_bad_op = 1'b1;
        endcase
    end

    always_comb begin
        w_known = 1'b1;
        w_old   = '0;
        unique case (csr_addr_i)
            CSR_MVENDORID: w_old = MVENDOR_ID;
            CSR_MARCHID:   w_old = MARCH_ID;
            CSR_MIMPID:    w_old = MIMP_ID;
            CSR_MHARTID:   w_old = HART_ID;
            CSR_MISA:      w_old = MISA_VALUE;
            CSR_MSTATUS: begin
                w_old[MSTATUS_MIE_BIT]  = mie_q;
                w_old[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MIE:       w_old[MIE_MEIE_BIT] = meie_q;
            CSR_MIP:       w_old[MEIP_BIT]     = meip_q;
            CSR_MEPC:      w_old = mepc_q;
            CSR_MCAUSE:    w_old = mcause_q;
            CSR_MTVAL:     w_old = mtval_q;
            CSR_TEST:      w_old = test_q;
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME:       w_old = w_mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH:    w_old = w_mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:             w_old = w_minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:           w_old = w_minstret[63:32];
            default:       w_known = 1'b0;
        endcase
    end

    assign w_illegal = !w_known || w_bad_op || (w_wr_req && csr_is_readonly(csr_addr_i));
    // A trap in the same cycle swallows the write but not the read response.
    assign w_wr_en   = csr_valid_i && !w_illegal && w_wr_req && !trap_i;

    zicsr_counter64 u_mcycle (
        .clk_i   (p_clk_i),
        .rst_i   (p_reset_i),
        .inc_i   (1'b1),
        .wr_lo_i (w_wr_en && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi_i (w_wr_en && (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i (w_new),
        .cnt_o   (w_mcycle)
    );

    zicsr_counter64 u_minstret (
        .clk_i   (p_clk_i),
        .rst_i   (p_reset_i),
        .inc_i   (instret_i),
        .wr_lo_i (w_wr_en && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi_i (w_wr_en && (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i (w_new),
        .cnt_o   (w_minstret)
    );

    always_ff @(posedge p_clk_i) begin
        if (p_reset_i) begin
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            test_q    <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            meie_q    <= 1'b0;
            meip_q    <= 1'b0;
        end else begin
            rvalid_q <= csr_valid_i;
            meip_q   <= irq_ext_i;
            if (csr_valid_i) begin
                illegal_q <= w_illegal;
                rdata_q   <= w_illegal ? 32'd0 : w_old;
            end
            if (w_wr_en) begin
                unique case (csr_addr_i)
                    CSR_TEST:   test_q   <= w_new;
                    CSR_MEPC:   mepc_q   <= w_new & ~32'd3;
                    CSR_MCAUSE: mcause_q <= w_new;
                    CSR_MTVAL:  mtval_q  <= w_new;
                    CSR_MIE:    meie_q   <= w_new[MIE_MEIE_BIT];
                    default: ;
                endcase
            end
            // Priority for mstatus: trap, then mret, then a CSR write.
            if (trap_i) begin
                mepc_q   <= trap_pc_i & ~32'd3;
                mcause_q <= trap_cause_i;
                mtval_q  <= trap_tval_i;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret_i) begin
                mie_q    <= mpie_q;
                mpie_q   <= 1'b1;
            end else if (w_wr_en && (csr_addr_i == CSR_MSTATUS)) begin
                mie_q    <= w_new[MSTATUS_MIE_BIT];
                mpie_q   <= w_new[MSTATUS_MPIE_BIT];
            end
        end
    end

    assign csr_rdata_o   = rdata_q;
    assign csr_rvalid_o  = rvalid_q;
    assign csr_illegal_o = illegal_q;
    assign mepc_o        = mepc_q;
    assign mstatus_mie_o = mie_q;

endmodule
`default_nettype wire

// File: tb/tb_zicsr_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_zicsr_csr_file
// Description : Directed, table-driven self-checking bench for zicsr_csr_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zicsr_csr_file;

    localparam logic [31:0] C_HART = 32'h0000_0005;
    localparam logic [31:0] C_VEND = 32'h0000_0A0B;
    localparam logic [31:0] C_ARCH = 32'h0000_0007;
    localparam logic [31:0] C_IMP  = 32'h0000_0009;
    localparam logic [31:0] C_MISA = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs1_idx;
    logic [31:0] rdata;
    logic        rvalid, illegal;
    logic        instret, trap, mret, irq;
    logic [31:0] trap_pc, trap_cause, trap_tval;
    logic [31:0] mepc;
    logic        mie;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zicsr_csr_file #(
        .HART_ID    (C_HART),
        .MVENDOR_ID (C_VEND),
        .MARCH_ID   (C_ARCH),
        .MIMP_ID    (C_IMP),
        .MISA_VALUE (C_MISA)
    ) dut (
        .p_clk_i        (clk),
        .p_reset_i      (rst),
        .csr_valid_i    (valid),
        .csr_funct3_i   (f3),
        .csr_addr_i     (addr),
        .csr_rs1_data_i (rs1_data),
        .csr_rs1_idx_i  (rs1_idx),
        .csr_rdata_o    (rdata),
        .csr_rvalid_o   (rvalid),
        .csr_illegal_o  (illegal),
        .instret_i      (instret),
        .trap_i         (trap),
        .trap_pc_i      (trap_pc),
        .trap_cause_i   (trap_cause),
        .trap_tval_i    (trap_tval),
        .mret_i         (mret),
        .mepc_o         (mepc),
        .mstatus_mie_o  (mie),
        .irq_ext_i      (irq)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] data;
        logic [4:0]  idx;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; drives one op for exactly one cycle and checks
    // the response one cycle later. Back-to-back calls issue back-to-back ops.
    task automatic op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] d,
                      input logic [4:0] i, input bit cmp_rd, input logic [31:0] er,
                      input logic ei, input string nm);
        valid = 1'b1; f3 = f; addr = a; rs1_data = d; rs1_idx = i;
        @(negedge clk);
        valid = 1'b0;
        chk({nm, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, ei});
        if (cmp_rd) chk({nm, "_rdata"}, rdata, er);
    endtask

    task automatic add(input logic [2:0] f, input logic [11:0] a, input logic [31:0] d,
                       input logic [4:0] i, input logic [31:0] er, input logic ei);
        vec_t v;
        v.f3 = f; v.addr = a; v.data = d; v.idx = i; v.exp_rdata = er; v.exp_ill = ei;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; f3 = '0; addr = '0; rs1_data = '0; rs1_idx = '0;
        instret = 1'b0; trap = 1'b0; mret = 1'b0; irq = 1'b0;
        trap_pc = '0; trap_cause = '0; trap_tval = '0;

        add(3'b001, 12'hBEB, 32'hDEADBEEF, 5'd5, 32'h0,        1'b0);
        add(3'b010, 12'hBEB, 32'h0,        5'd0, 32'hDEADBEEF, 1'b0);
        add(3'b011, 12'hBEB, 32'h0000FFFF, 5'd3, 32'hDEADBEEF, 1'b0);
        add(3'b010, 12'hBEB, 32'h00000011, 5'd2, 32'hDEAD0000, 1'b0);
        add(3'b101, 12'hBEB, 32'h0,        5'd7, 32'hDEAD0011, 1'b0);
        add(3'b110, 12'hBEB, 32'h0,        5'd8, 32'h7,        1'b0);
        add(3'b111, 12'hBEB, 32'h0,        5'd1, 32'hF,        1'b0);
        add(3'b011, 12'hBEB, 32'hFFFFFFFF, 5'd0, 32'hE,        1'b0);
        add(3'b010, 12'hBEB, 32'h0,        5'd0, 32'hE,        1'b0);
        add(3'b001, 12'hF14, 32'h1,        5'd1, 32'h0,        1'b1);
        add(3'b010, 12'hF14, 32'h0,        5'd0, C_HART,       1'b0);
        add(3'b110, 12'hF14, 32'h0,        5'd0, C_HART,       1'b0);
        add(3'b010, 12'hF11, 32'h0,        5'd0, C_VEND,       1'b0);
        add(3'b010, 12'hF12, 32'h0,        5'd0, C_ARCH,       1'b0);
        add(3'b010, 12'hF13, 32'h0,        5'd0, C_IMP,        1'b0);
        add(3'b010, 12'h7C0, 32'h0,        5'd0, 32'h0,        1'b1);
        add(3'b000, 12'hBEB, 32'h1,        5'd1, 32'h0,        1'b1);
        add(3'b100, 12'hBEB, 32'h1,        5'd1, 32'h0,        1'b1);
        add(3'b001, 12'hC00, 32'h0,        5'd0, 32'h0,        1'b1);
        add(3'b010, 12'hBEB, 32'h0,        5'd0, 32'hE,        1'b0);
        add(3'b001, 12'h301, 32'h0,        5'd4, C_MISA,       1'b0);
        add(3'b010, 12'h301, 32'h0,        5'd0, C_MISA,       1'b0);
        add(3'b001, 12'h300, 32'hFFFFFFFF, 5'd1, 32'h0,        1'b0);
        add(3'b010, 12'h300, 32'h0,        5'd0, 32'h88,       1'b0);
        add(3'b001, 12'h300, 32'h8,        5'd1, 32'h88,       1'b0);
        add(3'b111, 12'h300, 32'h0,        5'd8, 32'h8,        1'b0);
        add(3'b010, 12'h300, 32'h0,        5'd0, 32'h0,        1'b0);
        add(3'b001, 12'h304, 32'hFFFFFFFF, 5'd1, 32'h0,        1'b0);
        add(3'b010, 12'h304, 32'h0,        5'd0, 32'h800,      1'b0);
        add(3'b001, 12'h341, 32'h00000107, 5'd1, 32'h0,        1'b0);
        add(3'b010, 12'h341, 32'h0,        5'd0, 32'h104,      1'b0);
        add(3'b001, 12'h342, 32'h8000000B, 5'd1, 32'h0,        1'b0);
        add(3'b010, 12'h342, 32'h0,        5'd0, 32'h8000000B, 1'b0);
        add(3'b001, 12'h343, 32'hCAFEF00D, 5'd1, 32'h0,        1'b0);
        add(3'b010, 12'h343, 32'h0,        5'd0, 32'hCAFEF00D, 1'b0);
        add(3'b001, 12'h344, 32'hFFFFFFFF, 5'd1, 32'h0,        1'b0);
        add(3'b010, 12'h344, 32'h0,        5'd0, 32'h0,        1'b0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_rvalid",  {31'd0, rvalid},  32'd0);
        chk("reset_rdata",   rdata,            32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        chk("reset_mepc",    mepc,             32'd0);
        chk("reset_mie",     {31'd0, mie},     32'd0);

        for (int k = 0; k < tbl.size(); k++)
            op(tbl[k].f3, tbl[k].addr, tbl[k].data, tbl[k].idx, 1'b1,
               tbl[k].exp_rdata, tbl[k].exp_ill, $sformatf("vec%0d", k));

        // rvalid is a single-cycle pulse; rdata holds while idle.
        @(negedge clk);
        chk("pulse_rvalid", {31'd0, rvalid}, 32'd0);
        chk("hold_rdata",   rdata,           32'd0);

        // Trap entry with a coincident mepc write, then mret.
        op(3'b001, 12'h300, 32'h8, 5'd1, 1'b1, 32'h0, 1'b0, "set_mie");
        chk("mie_set", {31'd0, mie}, 32'd1);
        trap = 1'b1; trap_pc = 32'h00000103; trap_cause = 32'h8000000B; trap_tval = 32'h55;
        op(3'b001, 12'h341, 32'h12345678, 5'd1, 1'b1, 32'h104, 1'b0, "trap_wr");
        trap = 1'b0;
        chk("trap_mepc_o", mepc,            32'h100);
        chk("trap_mie_o",  {31'd0, mie},    32'd0);
        op(3'b010, 12'h341, 32'h0, 5'd0, 1'b1, 32'h100,      1'b0, "trap_mepc");
        op(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 32'h80,       1'b0, "trap_mstatus");
        op(3'b010, 12'h342, 32'h0, 5'd0, 1'b1, 32'h8000000B, 1'b0, "trap_mcause");
        op(3'b010, 12'h343, 32'h0, 5'd0, 1'b1, 32'h55,       1'b0, "trap_mtval");
        mret = 1'b1;
        op(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 32'h80, 1'b0, "mret_rd");
        mret = 1'b0;
        chk("mret_mie_o", {31'd0, mie}, 32'd1);
        op(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 32'h88, 1'b0, "mret_mstatus");
        trap = 1'b1; mret = 1'b1;
        op(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 32'h88, 1'b0, "trapmret_rd");
        trap = 1'b0; mret = 1'b0;
        op(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 32'h80, 1'b0, "trapmret_mstatus");
        mret = 1'b1;
        op(3'b001, 12'h300, 32'h0, 5'd1, 1'b1, 32'h80, 1'b0, "mretwr_rd");
        mret = 1'b0;
        op(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 32'h88, 1'b0, "mretwr_mstatus");

        // mip.MEIP is a registered copy of the external interrupt line.
        irq = 1'b1;
        op(3'b010, 12'h344, 32'h0, 5'd0, 1'b1, 32'h0,   1'b0, "mip_first");
        op(3'b010, 12'h344, 32'h0, 5'd0, 1'b1, 32'h800, 1'b0, "mip_second");
        irq = 1'b0;

        // mcycle carry from a written low half; half writes suppress increment.
        op(3'b001, 12'hB00, 32'hFFFFFFFF, 5'd1, 1'b0, 32'h0, 1'b0, "mcyc_wr_lo");
        op(3'b001, 12'hB80, 32'h0,        5'd1, 1'b0, 32'h0, 1'b0, "mcyc_wr_hi");
        op(3'b010, 12'hB80, 32'h0, 5'd0, 1'b1, 32'h0, 1'b0, "mcych_rd1");
        op(3'b010, 12'hB80, 32'h0, 5'd0, 1'b1, 32'h1, 1'b0, "mcych_rd2");
        op(3'b010, 12'hB00, 32'h0, 5'd0, 1'b1, 32'h1, 1'b0, "mcyc_lo_rd");
        op(3'b010, 12'hC81, 32'h0, 5'd0, 1'b1, 32'h1, 1'b0, "timeh_rd");
        instret = 1'b1;
        op(3'b001, 12'hB02, 32'h100, 5'd1, 1'b1, 32'h0,   1'b0, "minst_wr");
        op(3'b010, 12'hB02, 32'h0,   5'd0, 1'b1, 32'h100, 1'b0, "minst_rd1");
        instret = 1'b0;
        op(3'b010, 12'hC02, 32'h0,   5'd0, 1'b1, 32'h101, 1'b0, "instret_rd");
        op(3'b010, 12'hB82, 32'h0,   5'd0, 1'b1, 32'h0,   1'b0, "minsth_rd");

        // Reset coincident with a CSR write: no response, no state change.
        rst = 1'b1;
        valid = 1'b1; f3 = 3'b001; addr = 12'hBEB; rs1_data = 32'h1234; rs1_idx = 5'd1;
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        chk("rstop_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rstop_rdata",  rdata,           32'd0);
        op(3'b010, 12'hB00, 32'h0, 5'd0, 1'b1, 32'h0, 1'b0, "rstop_mcycle");
        op(3'b010, 12'hBEB, 32'h0, 5'd0, 1'b1, 32'h0, 1'b0, "rstop_test");
        chk("rstop_mepc", mepc,         32'd0);
        chk("rstop_mie",  {31'd0, mie}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
